// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux_rr registered N-to-1 stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker: first requester after ptr, wrapping mod N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  int unsigned cand;

  // Walk ptr+1 .. ptr+N; the first hit keeps the grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!gnt_valid && req[cand[SEL_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream mux with fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  input  logic             out_ready
);

  logic [W-1:0]     chan_data [N];
  logic [SEL_W-1:0] ptr;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             sel_ok;
  logic             load;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             rr_eff;
  logic             xfer;
  logic             is_last;
  logic             locked;
  logic [SEL_W-1:0] lock_chan;
  logic             lock_rr;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan_data[k] = in_data[k*W +: W];
  end

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign sel_ok = {1'b0, sel} < (SEL_W+1)'(N);
  assign load   = !out_valid || out_ready;
  assign xfer   = load && gnt_valid;

  // Grant source: an open packet overrides mode/sel; rr_eff says whether ptr may advance.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    rr_eff    = 1'b0;
    if (locked) begin
      gnt_valid = in_valid[lock_chan];
      gnt_idx   = lock_chan;
      rr_eff    = lock_rr;
    end else if (mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
      rr_eff    = 1'b1;
    end else begin
      gnt_valid = sel_ok && in_valid[sel];
      gnt_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign is_last = in_last[gnt_idx];

  // Lock opens on a non-last beat and closes on the accepted last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked    <= 1'b0;
      lock_chan <= '0;
      lock_rr   <= 1'b0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      locked    <= !is_last;
      lock_chan <= gnt_idx;
      lock_rr   <= rr_eff;
      out_last  <= is_last;
    end
  end
`else
  assign is_last   = 1'b1;
  assign locked    = 1'b0;
  assign lock_chan = '0;
  assign lock_rr   = 1'b0;
`endif

  // Output beat register and RR pointer; a stalled beat holds until out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(N - 1);
    end else if (load) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= chan_data[gnt_idx];
        out_chan  <= gnt_idx;
        if (rr_eff && is_last) ptr <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, W=8) against a behavioural model.
module tb_stream_mux_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  in_last;
  logic        out_last;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // Model state: what the output register and arbiter must hold.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;
  bit       m_locked;
  int       m_lchan;
  bit       m_lrr;
  bit       m_last;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

`ifndef STREAM_MUX_PKT_LOCK_EN
  assign out_last = 1'b1;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_ptr = N - 1;
    m_locked = 0; m_lchan = 0; m_lrr = 0; m_last = 0;
  endtask

  // Grant from the rules: open packet wins; else RR = nearest valid after ptr; else sel.
  task automatic model_grant(input bit md, input bit [1:0] s, input bit [3:0] v,
                             output bit gv, output int g, output bit rr);
    int bestd;
    gv = 0; g = 0; rr = 0; bestd = N;
    if (m_locked) begin
      gv = v[m_lchan]; g = m_lchan; rr = m_lrr;
    end else if (md) begin
      rr = 1;
      for (int k = 0; k < N; k++) begin
        int d;
        d = (k - m_ptr - 1 + 2 * N) % N;
        if (v[k] && d < bestd) begin bestd = d; g = k; gv = 1; end
      end
    end else begin
      g = s; gv = (s < N) && v[s];
    end
  endtask

  // One clock: drive inputs, check in_ready, advance model, check registered outputs.
  task automatic cycle(input bit rst, input bit md, input bit [1:0] s, input bit [3:0] v,
                       input bit [31:0] d, input bit ordy, input bit [3:0] lst);
    bit gv, rr, load;
    int g;
    logic [3:0] exp_rdy;
    reset = rst; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy; in_last = lst;
    #1;
    model_grant(md, s, v, gv, g, rr);
    load = !m_valid || ordy;
    exp_rdy = (load && gv) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    if (rst) model_reset();
    else if (load) begin
      if (gv) begin
        m_valid = 1; m_data = d[g*8 +: 8]; m_chan = g; m_last = lst[g];
        if (rr && lst[g]) m_ptr = g;
        m_locked = !lst[g]; m_lchan = g; m_lrr = rr;
      end else m_valid = 0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_chan", 32'(out_chan), 32'(m_chan));
`ifdef STREAM_MUX_PKT_LOCK_EN
    chk("out_last", 32'(out_last), 32'(m_last));
`endif
  endtask

  initial begin
    bit [7:0] fx [4];
    bit [1:0] rr_alt [4];
    fx = '{8'h11, 8'h22, 8'h33, 8'h44};
    rr_alt = '{2'd1, 2'd3, 2'd1, 2'd3};
    reset = 1; mode = 0; sel = 0; in_valid = 0; in_data = 0; out_ready = 0; in_last = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);

    // Fixed select stepping through every channel.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 2'(i), 4'hF, 32'h44332211, 1, 4'hF);
      chk("fix_data", 32'(out_data), 32'(fx[i]));
      chk("fix_chan", 32'(out_chan), 32'(i));
    end

    // Round-robin fairness, all valid then only channels 1 and 3.
    cycle(1, 0, 0, 0, 0, 1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 0, 4'hF, 32'h44332211, 1, 4'hF);
      chk("rr_chan", 32'(out_chan), 32'(i % 4));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 4'b1010, 32'h44332211, 1, 4'hF);
      chk("rr_alt_chan", 32'(out_chan), 32'(rr_alt[i]));
    end

    // Backpressure on a channel-2 beat, then release.
    cycle(1, 0, 0, 0, 0, 1, 4'hF);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'hF, 32'h44332211, 1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 4'hF, 32'h44332211, 0, 4'hF);
      chk("bp_chan", 32'(out_chan), 32'd2);
      chk("bp_data", 32'(out_data), 32'h33);
    end
    cycle(0, 1, 0, 4'hF, 32'h44332211, 1, 4'hF);
    chk("bp_release_chan", 32'(out_chan), 32'd3);

    // Selected channel idle: beat drains, out_valid drops.
    cycle(0, 0, 1, 4'b1101, 32'h44332211, 1, 4'hF);
    chk("sel_idle_valid", 32'(out_valid), 32'd0);

    // Reset while a beat is held.
    cycle(0, 1, 0, 4'hF, 32'h44332211, 0, 4'hF);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    cycle(1, 1, 0, 4'hF, 32'h44332211, 0, 4'hF);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    cycle(0, 1, 0, 4'hF, 32'h44332211, 1, 4'hF);
    chk("post_rst_chan", 32'(out_chan), 32'd0);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Channel 1 three-beat packet while channel 2 waits.
    cycle(1, 0, 0, 0, 0, 1, 4'hF);
    cycle(0, 1, 0, 4'b0110, 32'h44332211, 1, 4'b1101);
    chk("pkt_chan0", 32'(out_chan), 32'd1);
    cycle(0, 1, 0, 4'b0110, 32'h44332211, 1, 4'b1101);
    chk("pkt_chan1", 32'(out_chan), 32'd1);
    cycle(0, 1, 0, 4'b0110, 32'h44332211, 1, 4'b1111);
    chk("pkt_chan2", 32'(out_chan), 32'd1);
    chk("pkt_last", 32'(out_last), 32'd1);
    cycle(0, 1, 0, 4'b0110, 32'h44332211, 1, 4'b1111);
    chk("pkt_next_chan", 32'(out_chan), 32'd2);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit [3:0] lst;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lst = 4'($urandom) | 4'($urandom);
`else
      lst = 4'hF;
`endif
      cycle($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom), 4'($urandom),
            $urandom, $urandom_range(0, 3) != 0, lst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 registered stream multiplexer; successor to the combinational mux4_to_1.
- Selects one of N valid/ready input channels, either by an explicit select or by round-robin arbitration, and presents the selected beat on one registered output with its source channel index.
- Sits between multiple producer channels and a single consumer, for example merging sensor or datapath lanes onto one bus.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SEL_W, $clog2(N), width of sel and out_chan (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel, 1 = round-robin.
- sel  input  SEL_W  channel select, used when mode=0.
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_ready  output  N  per-channel accept, combinational.
- out_valid  output  1  output beat valid.
- out_data  output  W  selected data.
- out_chan  output  SEL_W  source channel of the current output beat.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (synchronous, active-high, one clk edge): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=N-1 so channel 0 wins first. Reset mid-transfer drops the held beat; nothing is replayed.
- load = !out_valid || out_ready. This gives full throughput of 1 beat/cycle with no bubble.
- Grant, mode=0:
  - g=sel if sel<N and in_valid[sel].
  - Otherwise no grant. sel>=N always means no grant.
- Grant, mode=1:
  - g = first k with in_valid[k], searching ptr+1, ptr+2, … mod N.
  - No grant if in_valid==0.
- Transfer: in_ready[g]=load when a grant exists; all other in_ready bits are 0. in_ready never depends on in_ready.
- On a transfer edge: out_data<=in_data[g], out_chan<=g, out_valid<=1. In mode=1, ptr<=g.
- On load with no grant: out_valid<=0. out_data and out_chan hold their last values.
- When out_valid=1 and out_ready=0: out_valid, out_data and out_chan hold stable; in_ready=0.
- Latency: input accept edge to out_valid is 1 cycle.
- ptr wraps N-1 → 0. ptr is unchanged while mode=0.
- mode or sel changes affect only the next grant decision, never a held output beat.

Optional Feature:
- Macro STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds ports in_last (input N) and out_last (output 1, reset 0); out_last is registered with out_data.
  - Once channel g transfers a beat with in_last[g]=0, the grant stays locked to g until a beat with in_last[g]=1 is accepted. Other channels get in_ready=0 during the lock.
  - mode and sel are ignored while locked. ptr updates only on the last beat.
  - Reset clears the lock.
- When undefined: no in_last/out_last ports; arbitration is per beat.

Decomposition:
- Shared package stream_mux_pkg holds MODE_FIXED=1'b0 and MODE_RR=1'b1, plus a clog2 helper function if the tool flow needs one.
- One sub-module, rr_arbiter: pure combinational N-way round-robin priority picker taking (req, ptr) and returning (gnt_valid, gnt_idx).
- The mux, output register and lock logic stay in stream_mux_rr.

Test Plan (N=4, W=8):
- Fixed select: mode=0, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1; sel stepped 0,1,2,3, one per cycle → out_data 11,22,33,44 one cycle after each, out_chan 0..3, in_ready one-hot matching sel.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles → out_chan 0,1,2,3,0,1,2,3. With only in_valid=4'b1010 → out_chan alternates 1,3.
- Backpressure: mode=1, out_valid=1 with out_chan=2, out_ready=0 for 3 cycles → out_data/out_chan stable, in_ready=0. Release out_ready → next out_chan=3 on the following edge.
- Boundaries: mode=0, sel=1 with in_valid[1]=0 → out_valid falls to 0 after the current beat drains. Reset asserted while out_valid=1 → next cycle out_valid=0, out_data=0, and the first RR grant afterwards is channel 0.
- Pkt lock (macro defined): channel 1 sends 3 beats with in_last=0,0,1 while channel 2 is valid → out_chan=1,1,1 and then 2; in_ready[2]=0 until channel 1's last beat is accepted.
